// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   rf_state_e : sweep FSM state encodings (RF_ST_INIT, RF_ST_RUN)
//   RF_ZERO    : clear value written by the sweep (sliced to XLEN, XLEN <= 64)
//   rf_clog2   : ceil(log2(v)) helper for address widths
package regfile_pkg;

  typedef enum logic {
    RF_ST_INIT = 1'b0,
    RF_ST_RUN  = 1'b1
  } rf_state_e;

  localparam logic [63:0] RF_ZERO = 64'd0;

  function automatic int rf_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus interface of regfile_mp_sb: read ports, write ports and issue port.
//   master : drives addresses, write data/enables, issue; receives read data/busy
//   slave  : the register file side
// Flat port packing: port k of a field of width W occupies bits [k*W +: W].
// There is no valid/ready handshake: wr_en_i / iss_en_i are single-cycle
// qualifiers sampled on the rising clock edge, reads are purely combinational.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 2,
  parameter int NW    = 1
);
  localparam int AW = rf_clog2(DEPTH);

  logic [NR*AW-1:0]   src_addr_i;
  logic [NR*XLEN-1:0] src_data_o;
  logic [NR-1:0]      src_busy_o;
  logic [NW-1:0]      wr_en_i;
  logic [NW*AW-1:0]   wr_addr_i;
  logic [NW*XLEN-1:0] wr_data_i;
  logic               iss_en_i;
  logic [AW-1:0]      iss_addr_i;

  modport master (
    output src_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
    input  src_data_o, src_busy_o
  );

  modport slave (
    input  src_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
    output src_data_o, src_busy_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register marking an in-flight producer.
//   clk, rst   : clock, synchronous active-high reset (clears all bits)
//   iss_en_i   : set pending[iss_addr_i]
//   wr_en_i    : per write port, clears pending[wr_addr_i[j]]
//   rd_addr_i  : NR lookup addresses (flat)
//   busy_o     : pending bit of each lookup address (registered state only)
// Enables arrive already gated by the caller while the array is not usable.
module regfile_scoreboard #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NR    = 2,
  parameter int NW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic [NW-1:0]    wr_en_i,
  input  logic [NW*AW-1:0] wr_addr_i,
  input  logic [NR*AW-1:0] rd_addr_i,
  output logic [NR-1:0]    busy_o
);

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;

  // Clears are applied first so a same-cycle issue (newer producer) wins.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int j = 0; j < NW; j++) begin
      if (wr_en_i[j]) w_pending_nxt[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (iss_en_i) w_pending_nxt[iss_addr_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < NR; k++) begin
      busy_o[k] = r_pending[rd_addr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with pending scoreboard.
//   clk, rst     : clock, synchronous active-high reset (restarts the sweep)
//   ready_o      : 1 once the post-reset sweep has cleared the array
//   dbg_state_o  : current sweep FSM state
//   bus (slave)  : NR async read ports, NW sync write ports, issue port
// Entry 0 is hardwired to zero. After reset the FSM clears entries 1..DEPTH-1,
// one per cycle; writes/issues are ignored and reads return 0 until done.
// Optional feature macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 2,
  parameter int NW    = 1
) (
  input  logic      clk,
  input  logic      rst,
  output logic      ready_o,
  output rf_state_e dbg_state_o,
  regfile_mp_sb_if.slave bus
);

  localparam int AW = rf_clog2(DEPTH);

  rf_state_e        r_state;
  rf_state_e        w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic             w_run;
  logic [NW-1:0]    w_wr_en;
  logic             w_iss_en;
  logic [NR-1:0]    w_sb_busy;
  logic [XLEN-1:0]  r_mem [DEPTH];

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_ST_INIT;
      r_ptr   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      RF_ST_INIT: begin
        w_ptr_nxt = r_ptr + AW'(1);
        if (r_ptr == AW'(DEPTH - 1)) w_state_nxt = RF_ST_RUN;
      end
      RF_ST_RUN: ;
      default: w_state_nxt = RF_ST_INIT;
    endcase
  end

  assign w_run       = (r_state == RF_ST_RUN);
  assign ready_o     = w_run;
  assign dbg_state_o = r_state;
  assign w_wr_en     = bus.wr_en_i & {NW{w_run}};
  assign w_iss_en    = bus.iss_en_i & w_run;

  // Array: sweep clear in INIT; in RUN later ports overwrite earlier ones,
  // so the highest port index wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_mem[r_ptr] <= RF_ZERO[XLEN-1:0];
      end else begin
        for (int j = 0; j < NW; j++) begin
          if (w_wr_en[j] && (bus.wr_addr_i[j*AW +: AW] != '0))
            r_mem[bus.wr_addr_i[j*AW +: AW]] <= bus.wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NR    (NR),
    .NW    (NW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (w_iss_en),
    .iss_addr_i (bus.iss_addr_i),
    .wr_en_i    (w_wr_en),
    .wr_addr_i  (bus.wr_addr_i),
    .rd_addr_i  (bus.src_addr_i),
    .busy_o     (w_sb_busy)
  );

  // Read ports: address 0 and the whole INIT phase read as 0 / not busy.
  always_comb begin : read_mux
    logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
    logic          hit;
`endif
    ra = '0;
    bus.src_data_o = '0;
    bus.src_busy_o = '0;
    for (int k = 0; k < NR; k++) begin
      ra = bus.src_addr_i[k*AW +: AW];
      if (w_run && (ra != '0)) begin
        bus.src_data_o[k*XLEN +: XLEN] = r_mem[ra];
        bus.src_busy_o[k]              = w_sb_busy[k];
`ifdef REGFILE_BYPASS_EN
        // Forward write data; a forwarded value is not busy unless the
        // same register is being re-issued this cycle.
        hit = 1'b0;
        for (int j = 0; j < NW; j++) begin
          if (w_wr_en[j] && (bus.wr_addr_i[j*AW +: AW] == ra)) begin
            bus.src_data_o[k*XLEN +: XLEN] = bus.wr_data_i[j*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
        if (hit) bus.src_busy_o[k] = w_iss_en && (bus.iss_addr_i == ra);
`endif
      end
    end
  end

endmodule
